// File: rtl/lifo_pkg.sv
// Shared constants and operation decode for the LIFO stack.
// Macro LIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
package lifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_SWAP
  } op_e;

  // Illegal requests collapse to IDLE; push+pop on empty is a plain push.
  function automatic op_e decode_op(
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
  );
    op_e op;
    op = OP_IDLE;
    unique case ({push, pop})
      2'b10:   op = full  ? OP_IDLE : OP_PUSH;
      2'b01:   op = empty ? OP_IDLE : OP_POP;
      2'b11:   op = empty ? OP_PUSH : OP_SWAP;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Push/pop handshake bundle between a producer (master) and the stack (slave).
// Signals: push, pop, data_in, data_out, out_valid, full, empty, count,
// plus overflow/underflow when LIFO_ERR_FLAGS_EN is defined.
interface lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
`ifdef LIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output push, pop, data_in,
`ifdef LIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  data_out, out_valid, full, empty, count
  );

  modport slave (
    input  push, pop, data_in,
`ifdef LIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output data_out, out_valid, full, empty, count
  );

endinterface

// File: rtl/lifo_ptr_ctrl.sv
// Stack pointer counter, full/empty/count and op decode.
// Ports: clk, reset, push, pop in; op, wr_idx, rd_idx, count, full, empty
// out (+ overflow/underflow with LIFO_ERR_FLAGS_EN).
module lifo_ptr_ctrl
  import lifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output op_e              op,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] count,
`ifdef LIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] sp_q, sp_d;

  assign full  = (sp_q == CNT_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign count = sp_q;
  assign op    = decode_op(push, pop, full, empty);

  // Swap overwrites the current top; push writes one above it.
  assign rd_idx = IDX_W'(sp_q - CNT_W'(1));
  assign wr_idx = (op == OP_PUSH) ? IDX_W'(sp_q) : rd_idx;

  always_comb begin
    sp_d = sp_q;
    unique case (op)
      OP_PUSH: sp_d = sp_q + CNT_W'(1);
      OP_POP:  sp_d = sp_q - CNT_W'(1);
      default: sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (push & ~pop & full);
    unf_d = unf_q | (pop & empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: rtl/lifo_stack.sv
// Register-based LIFO with registered pop data and a one-cycle out_valid.
// Ports: clk, reset (async, active high), bus (lifo_stack_if.slave).
// Optional sticky error flags via LIFO_ERR_FLAGS_EN.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         reset,
  lifo_stack_if.slave bus
);

  op_e              op;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;

  lifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.push),
    .pop       (bus.pop),
    .op        (op),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx),
    .count     (bus.count),
`ifdef LIFO_ERR_FLAGS_EN
    .overflow  (bus.overflow),
    .underflow (bus.underflow),
`endif
    .full      (bus.full),
    .empty     (bus.empty)
  );

  // Storage is never reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (op == OP_PUSH || op == OP_SWAP)
      mem_q[wr_idx] <= bus.data_in;
  end

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (op == OP_POP || op == OP_SWAP) begin
      data_out_d  = mem_q[rd_idx];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;

endmodule
